// File: rtl/retire_commit_wide.sv
// In-order retirement unit: circular reorder buffer with one allocation per
// cycle, NUM_WB completion ports, up to RETIRE_WIDTH commits per cycle into
// the retirement RAT, free-list return of previous mappings, and a registered
// flush when the oldest non-retiring entry completed with an exception.
module retire_commit_wide #(
   parameter int NUM_PHYS_REGS = 64,
   parameter int NUM_ARCH_REGS = 35,
   parameter int ROB_DEPTH     = 64,
   parameter int RETIRE_WIDTH  = 2,
   parameter int NUM_WB        = 2,
   localparam int LOG_PHYS  = $clog2(NUM_PHYS_REGS),
   localparam int LOG_ARCH  = $clog2(NUM_ARCH_REGS),
   localparam int LOG_DEPTH = $clog2(ROB_DEPTH)
) (
   input  logic                              CLK,
   input  logic                              RESET,
   input  logic                              Alloc_valid_IN,
   input  logic [LOG_ARCH-1:0]               Alloc_arch_IN,
   input  logic [LOG_PHYS-1:0]               Alloc_phys_IN,
   input  logic [LOG_PHYS-1:0]               Alloc_old_phys_IN,
   input  logic                              Alloc_has_dest_IN,
   output logic                              Alloc_ready_OUT,
   output logic [LOG_DEPTH-1:0]              Alloc_tag_OUT,
   input  logic [NUM_WB-1:0]                 Complete_valid_IN,
   input  logic [NUM_WB*LOG_DEPTH-1:0]       Complete_tag_IN,
   input  logic [NUM_WB-1:0]                 Complete_exc_IN,
   output logic [RETIRE_WIDTH-1:0]           Retire_valid_OUT,
   output logic [RETIRE_WIDTH*LOG_PHYS-1:0]  Free_phys_OUT,
   output logic [RETIRE_WIDTH-1:0]           Free_valid_OUT,
   output logic                              Flush_OUT,
   output logic [NUM_ARCH_REGS*LOG_PHYS-1:0] RegPtrs_OUT,
   output logic [LOG_DEPTH:0]                Count_OUT
);

   localparam int CNT_W = LOG_DEPTH + 1;

   logic [ROB_DEPTH-1:0]    valid_q, done_q, exc_q, has_dest_q;
   logic [ROB_DEPTH-1:0]    valid_d, done_d, exc_d;
   logic [ROB_DEPTH-1:0]    done_set, exc_set;
   logic [LOG_ARCH-1:0]     arch_q     [ROB_DEPTH];
   logic [LOG_PHYS-1:0]     phys_q     [ROB_DEPTH];
   logic [LOG_PHYS-1:0]     old_phys_q [ROB_DEPTH];
   logic [LOG_DEPTH-1:0]    head_q, tail_q, head_d, tail_d;
   logic [CNT_W-1:0]        count_q, count_d, nret;
   logic [LOG_PHYS-1:0]     rrat_q [NUM_ARCH_REGS];
   logic [LOG_PHYS-1:0]     rrat_d [NUM_ARCH_REGS];
   logic [LOG_DEPTH-1:0]    slot_idx [RETIRE_WIDTH];
   logic [RETIRE_WIDTH-1:0] retire_d, retire_q, free_valid_d, free_valid_q;
   logic [RETIRE_WIDTH*LOG_PHYS-1:0] free_phys_d, free_phys_q;
   logic                    flush_now, flush_q, alloc_fire;

   assign Alloc_ready_OUT  = (count_q != CNT_W'(ROB_DEPTH));
   assign Alloc_tag_OUT    = tail_q;
   assign Count_OUT        = count_q;
   assign Retire_valid_OUT = retire_q;
   assign Free_valid_OUT   = free_valid_q;
   assign Free_phys_OUT    = free_phys_q;
   assign Flush_OUT        = flush_q;

   // Flatten the RRAT onto the output bus.
   always_comb begin
      RegPtrs_OUT = '0;
      for (int unsigned r = 0; r < NUM_ARCH_REGS; r++)
         RegPtrs_OUT[r*LOG_PHYS +: LOG_PHYS] = rrat_q[r];
   end

   // Retire scan: stop at the first slot that is out of range, not done or
   // excepting; an excepting done entry at that point raises the flush.
   always_comb begin
      logic blocked;
      logic in_range;
      blocked   = 1'b0;
      in_range  = 1'b0;
      retire_d  = '0;
      nret      = '0;
      flush_now = 1'b0;
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
         slot_idx[i] = head_q + LOG_DEPTH'(i);
         in_range    = (CNT_W'(i) < count_q);
         if (!blocked) begin
            if (in_range && valid_q[slot_idx[i]] && done_q[slot_idx[i]] &&
                !exc_q[slot_idx[i]]) begin
               retire_d[i] = 1'b1;
               nret        = nret + CNT_W'(1);
            end else begin
               blocked = 1'b1;
               if (in_range && valid_q[slot_idx[i]] && done_q[slot_idx[i]] &&
                   exc_q[slot_idx[i]])
                  flush_now = 1'b1;
            end
         end
      end
   end

   // Commit side effects: RRAT writes in slot order so the youngest wins,
   // plus the free-list return per retired slot.
   always_comb begin
      rrat_d       = rrat_q;
      free_valid_d = '0;
      free_phys_d  = '0;
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
         if (retire_d[i]) begin
            free_phys_d[i*LOG_PHYS +: LOG_PHYS] = old_phys_q[slot_idx[i]];
            if (has_dest_q[slot_idx[i]]) begin
               rrat_d[arch_q[slot_idx[i]]] = phys_q[slot_idx[i]];
               free_valid_d[i]             = 1'b1;
            end
         end
      end
   end

   // Completion ports are merged first so duplicate tags OR their exc flags.
   always_comb begin
      done_set = '0;
      exc_set  = '0;
      for (int unsigned k = 0; k < NUM_WB; k++) begin
         if (Complete_valid_IN[k] && valid_q[Complete_tag_IN[k*LOG_DEPTH +: LOG_DEPTH]]) begin
            done_set[Complete_tag_IN[k*LOG_DEPTH +: LOG_DEPTH]] = 1'b1;
            exc_set[Complete_tag_IN[k*LOG_DEPTH +: LOG_DEPTH]] =
               exc_set[Complete_tag_IN[k*LOG_DEPTH +: LOG_DEPTH]] | Complete_exc_IN[k];
         end
      end
   end

   // Next-state for entry flags and pointers.
   always_comb begin
      alloc_fire = Alloc_valid_IN && Alloc_ready_OUT && !flush_now;
      valid_d    = valid_q;
      done_d     = done_q | done_set;
      exc_d      = exc_q | exc_set;
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++)
         if (retire_d[i]) valid_d[slot_idx[i]] = 1'b0;
      if (alloc_fire) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         exc_d[tail_q]   = 1'b0;
      end
      if (flush_now) valid_d = '0;
      head_d  = flush_now ? tail_q : head_q + LOG_DEPTH'(nret);
      tail_d  = tail_q + LOG_DEPTH'(alloc_fire);
      count_d = flush_now ? '0 : count_q + CNT_W'(alloc_fire) - nret;
   end

   // Entry payload, written only on allocation.
   always_ff @(posedge CLK) begin
      if (alloc_fire) begin
         arch_q[tail_q]     <= Alloc_arch_IN;
         phys_q[tail_q]     <= Alloc_phys_IN;
         old_phys_q[tail_q] <= Alloc_old_phys_IN;
         has_dest_q[tail_q] <= Alloc_has_dest_IN;
      end
   end

   // Control state, RRAT and registered retire/free/flush outputs.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         valid_q      <= '0;
         done_q       <= '0;
         exc_q        <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         retire_q     <= '0;
         free_valid_q <= '0;
         free_phys_q  <= '0;
         flush_q      <= 1'b0;
         for (int unsigned r = 0; r < NUM_ARCH_REGS; r++)
            rrat_q[r] <= LOG_PHYS'(r);
      end else begin
         valid_q      <= valid_d;
         done_q       <= done_d;
         exc_q        <= exc_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         retire_q     <= retire_d;
         free_valid_q <= free_valid_d;
         free_phys_q  <= free_phys_d;
         flush_q      <= flush_now;
         rrat_q       <= rrat_d;
      end
   end

endmodule

// File: tb/tb_retire_commit_wide.sv
// Scoreboard bench for retire_commit_wide: an in-order queue model predicts
// each edge's outputs, the prediction is queued when stimulus is driven and
// compared against the DUT just after the edge.
module tb_retire_commit_wide;

   localparam int LP  = 6;
   localparam int LA  = 6;
   localparam int LD  = 6;
   localparam int RW  = 2;
   localparam int NW  = 2;
   localparam int NA  = 35;
   localparam int DEP = 64;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              Alloc_valid_IN;
   logic [LA-1:0]     Alloc_arch_IN;
   logic [LP-1:0]     Alloc_phys_IN;
   logic [LP-1:0]     Alloc_old_phys_IN;
   logic              Alloc_has_dest_IN;
   logic              Alloc_ready_OUT;
   logic [LD-1:0]     Alloc_tag_OUT;
   logic [NW-1:0]     Complete_valid_IN;
   logic [NW*LD-1:0]  Complete_tag_IN;
   logic [NW-1:0]     Complete_exc_IN;
   logic [RW-1:0]     Retire_valid_OUT;
   logic [RW*LP-1:0]  Free_phys_OUT;
   logic [RW-1:0]     Free_valid_OUT;
   logic              Flush_OUT;
   logic [NA*LP-1:0]  RegPtrs_OUT;
   logic [LD:0]       Count_OUT;

   retire_commit_wide #(
      .NUM_PHYS_REGS(64), .NUM_ARCH_REGS(NA), .ROB_DEPTH(DEP),
      .RETIRE_WIDTH(RW), .NUM_WB(NW)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .Alloc_valid_IN(Alloc_valid_IN), .Alloc_arch_IN(Alloc_arch_IN),
      .Alloc_phys_IN(Alloc_phys_IN), .Alloc_old_phys_IN(Alloc_old_phys_IN),
      .Alloc_has_dest_IN(Alloc_has_dest_IN), .Alloc_ready_OUT(Alloc_ready_OUT),
      .Alloc_tag_OUT(Alloc_tag_OUT), .Complete_valid_IN(Complete_valid_IN),
      .Complete_tag_IN(Complete_tag_IN), .Complete_exc_IN(Complete_exc_IN),
      .Retire_valid_OUT(Retire_valid_OUT), .Free_phys_OUT(Free_phys_OUT),
      .Free_valid_OUT(Free_valid_OUT), .Flush_OUT(Flush_OUT),
      .RegPtrs_OUT(RegPtrs_OUT), .Count_OUT(Count_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [LD-1:0] tag;
      logic [LA-1:0] arch;
      logic [LP-1:0] phys;
      logic [LP-1:0] old;
      logic          hd;
      logic          done;
      logic          exc;
   } ent_t;

   typedef struct {
      logic [RW-1:0]    rv;
      logic [RW-1:0]    fv;
      logic [RW*LP-1:0] fp;
      logic             fl;
      logic [LD:0]      cnt;
      logic             rdy;
      logic [LD-1:0]    tag;
      logic [NA*LP-1:0] rrat;
   } exp_t;

   ent_t          rob[$];
   exp_t          exp_q[$];
   logic [LP-1:0] m_rrat [NA];
   logic [LD-1:0] m_tail;
   int            n_chk;
   int            n_fail;
   int            acc_alloc;
   logic [LD-1:0] t0, t1, t2;
   logic [LP-1:0] pre6, pre9;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      Alloc_valid_IN    = 1'b0;
      Alloc_arch_IN     = '0;
      Alloc_phys_IN     = '0;
      Alloc_old_phys_IN = '0;
      Alloc_has_dest_IN = 1'b0;
      Complete_valid_IN = '0;
      Complete_tag_IN   = '0;
      Complete_exc_IN   = '0;
   endtask

   task automatic set_alloc(input logic [LA-1:0] a, input logic [LP-1:0] p,
                            input logic [LP-1:0] o, input logic hd);
      Alloc_valid_IN    = 1'b1;
      Alloc_arch_IN     = a;
      Alloc_phys_IN     = p;
      Alloc_old_phys_IN = o;
      Alloc_has_dest_IN = hd;
   endtask

   task automatic rand_alloc();
      set_alloc(LA'($urandom_range(0, NA-1)), LP'($urandom_range(0, 63)),
                LP'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
   endtask

   task automatic set_comp(input int k, input logic [LD-1:0] t, input logic x);
      Complete_valid_IN[k]        = 1'b1;
      Complete_tag_IN[k*LD +: LD] = t;
      Complete_exc_IN[k]          = x;
   endtask

   function automatic int pick_undone();
      int s;
      int st;
      int x;
      s = rob.size();
      if (s == 0) return -1;
      st = $urandom_range(0, s-1);
      for (int j = 0; j < s; j++) begin
         x = (st + j) % s;
         if (!rob[x].done) return x;
      end
      return -1;
   endfunction

   task automatic rand_comps();
      int x;
      for (int k = 0; k < NW; k++) begin
         x = pick_undone();
         if (x >= 0 && $urandom_range(0, 1) == 1) set_comp(k, rob[x].tag, 1'b0);
      end
   endtask

   // Predict the edge, queue the prediction, then compare after the edge.
   task automatic step();
      exp_t e;
      ent_t en;
      int   n;
      int   sz0;
      bit   fl;
      e.rv = '0; e.fv = '0; e.fp = '0; e.fl = 1'b0;
      if (RESET === 1'b0) begin
         rob.delete();
         m_tail = '0;
         for (int r = 0; r < NA; r++) m_rrat[r] = LP'(r);
      end else begin
         sz0 = rob.size();
         n = 0;
         while (n < RW && n < rob.size() && rob[n].done && !rob[n].exc) n++;
         fl = (n < RW && n < rob.size() && rob[n].done && rob[n].exc);
         for (int i = 0; i < n; i++) begin
            en = rob.pop_front();
            e.rv[i] = 1'b1;
            e.fv[i] = en.hd;
            e.fp[i*LP +: LP] = en.old;
            if (en.hd) m_rrat[en.arch] = en.phys;
         end
         e.fl = fl;
         if (fl) begin
            rob.delete();
         end else begin
            for (int k = 0; k < NW; k++)
               if (Complete_valid_IN[k])
                  for (int j = 0; j < rob.size(); j++)
                     if (rob[j].tag == Complete_tag_IN[k*LD +: LD]) begin
                        en = rob[j];
                        en.done = 1'b1;
                        en.exc  = en.exc | Complete_exc_IN[k];
                        rob[j]  = en;
                     end
            if (Alloc_valid_IN && sz0 != DEP) begin
               en.tag  = m_tail;
               en.arch = Alloc_arch_IN;
               en.phys = Alloc_phys_IN;
               en.old  = Alloc_old_phys_IN;
               en.hd   = Alloc_has_dest_IN;
               en.done = 1'b0;
               en.exc  = 1'b0;
               rob.push_back(en);
               m_tail = m_tail + 1'b1;
               acc_alloc++;
            end
         end
      end
      e.cnt = 7'(rob.size());
      e.rdy = (rob.size() != DEP);
      e.tag = m_tail;
      for (int r = 0; r < NA; r++) e.rrat[r*LP +: LP] = m_rrat[r];
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      check_eq("retire_valid", Retire_valid_OUT, e.rv);
      check_eq("free_valid",   Free_valid_OUT,   e.fv);
      check_eq("free_phys",    Free_phys_OUT,    e.fp);
      check_eq("flush",        Flush_OUT,        e.fl);
      check_eq("count",        Count_OUT,        e.cnt);
      check_eq("ready",        Alloc_ready_OUT,  e.rdy);
      check_eq("alloc_tag",    Alloc_tag_OUT,    e.tag);
      check_eq("rrat",         RegPtrs_OUT,      e.rrat);
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      acc_alloc = 0;
      RESET = 1'b0;
      idle_in();
      step();
      step();
      RESET = 1'b1;
      step();
      check_eq("reset_rrat34", RegPtrs_OUT[34*LP +: LP], 6'd34);
      check_eq("reset_count",  Count_OUT, 7'd0);

      // Two writers of arch 3 retiring together.
      set_alloc(6'd3, 6'd40, 6'd3, 1'b1);  step();
      set_alloc(6'd3, 6'd41, 6'd40, 1'b1); step();
      idle_in(); set_comp(0, 6'd0, 1'b0); set_comp(1, 6'd1, 1'b0); step();
      idle_in(); step();
      check_eq("pair_rrat3",  RegPtrs_OUT[3*LP +: LP], 6'd41);
      check_eq("pair_free",   Free_phys_OUT, {6'd40, 6'd3});
      check_eq("pair_fvalid", Free_valid_OUT, 2'b11);
      step();

      // Strobe to an invalid entry is ignored.
      set_comp(0, 6'd10, 1'b1); step();
      idle_in(); step();

      // Out-of-order completion holds retirement.
      set_alloc(6'd7, 6'd20, 6'd7, 1'b1); step();
      set_alloc(6'd8, 6'd21, 6'd8, 1'b0); step();
      idle_in(); set_comp(0, 6'd3, 1'b0); step();
      idle_in(); step(); step();
      check_eq("ooo_hold", Retire_valid_OUT, 2'b00);
      set_comp(1, 6'd2, 1'b0); step();
      idle_in(); step();
      check_eq("ooo_both", Retire_valid_OUT, 2'b11);
      step();

      // Fill, overflow attempts, retire two, then wrap traffic.
      acc_alloc = 0;
      for (int i = 0; i < DEP; i++) begin rand_alloc(); step(); end
      check_eq("full_ready", Alloc_ready_OUT, 1'b0);
      check_eq("full_count", Count_OUT, 7'd64);
      for (int i = 0; i < 3; i++) begin rand_alloc(); step(); end
      rand_alloc(); set_comp(0, rob[0].tag, 1'b0); set_comp(1, rob[1].tag, 1'b0); step();
      idle_in(); rand_alloc(); step();
      check_eq("after2_count", Count_OUT, 7'd62);
      check_eq("after2_ready", Alloc_ready_OUT, 1'b1);
      rand_alloc(); step();
      for (int cyc = 0; cyc < 3000 && acc_alloc < 200; cyc++) begin
         idle_in();
         if ($urandom_range(0, 3) != 0) rand_alloc();
         rand_comps();
         step();
      end
      check_eq("wrap_allocs", 32'(acc_alloc >= 200), 32'd1);
      for (int cyc = 0; cyc < 400 && rob.size() > 0; cyc++) begin
         idle_in(); rand_comps(); step();
      end
      idle_in(); step(); step();
      check_eq("drained", Count_OUT, 7'd0);

      // Exception on the second entry.
      pre6 = m_rrat[6];
      pre9 = m_rrat[9];
      t0 = m_tail; set_alloc(6'd5, 6'd50, 6'd5, 1'b1); step();
      t1 = m_tail; set_alloc(6'd6, 6'd51, 6'd6, 1'b1); step();
      t2 = m_tail; set_alloc(6'd9, 6'd52, 6'd9, 1'b1); step();
      idle_in(); set_comp(0, t1, 1'b1); set_comp(1, t2, 1'b0); step();
      idle_in(); set_comp(0, t0, 1'b0); step();
      idle_in(); set_alloc(6'd12, 6'd60, 6'd12, 1'b1); step();
      check_eq("exc_flush",  Flush_OUT, 1'b1);
      check_eq("exc_count",  Count_OUT, 7'd0);
      check_eq("exc_retire", Retire_valid_OUT, 2'b01);
      check_eq("exc_rrat5",  RegPtrs_OUT[5*LP +: LP], 6'd50);
      check_eq("exc_rrat6",  RegPtrs_OUT[6*LP +: LP], pre6);
      check_eq("exc_rrat9",  RegPtrs_OUT[9*LP +: LP], pre9);
      check_eq("exc_tag",    Alloc_tag_OUT, t2 + 6'd1);
      idle_in(); step();
      check_eq("exc_pulse_end", Flush_OUT, 1'b0);

      // Mid-stream reset with ten entries in flight.
      for (int i = 0; i < 10; i++) begin rand_alloc(); step(); end
      idle_in(); set_comp(0, rob[0].tag, 1'b0); set_comp(1, rob[1].tag, 1'b0); step();
      RESET = 1'b0; rand_alloc(); set_comp(0, rob[2].tag, 1'b0); step();
      RESET = 1'b1; idle_in(); step();
      check_eq("rst_count",  Count_OUT, 7'd0);
      check_eq("rst_retire", Retire_valid_OUT, 2'b00);
      check_eq("rst_tag",    Alloc_tag_OUT, 6'd0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
